// File: rtl/riscv_sim_pkg.sv
// rtl/riscv_sim_pkg.sv - shared types for the RISC-V run monitor
package riscv_sim_pkg;

    localparam int unsigned TRACE_XLEN = 32;

    typedef enum logic [1:0] {HOLD, RUN, HALTED} state_e;

    typedef enum logic [1:0] {NONE, RD, PC, TIMEOUT} cause_e;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/riscv_run_monitor_trace_ring.sv
// rtl/riscv_run_monitor_trace_ring.sv - newest-first ring of recent write-backs
module trace_ring #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 69
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [IDX_W-1:0] wptr_q, wptr_d, rd_ptr;
    logic [IDX_W:0]   count_q, count_d;

    // Storage needs no reset: count_q alone decides which slots are readable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
            if (count_q != (IDX_W+1)'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign rd_ptr   = wptr_q - IDX_W'(1) - rd_idx;
    assign rd_valid = ({1'b0, rd_idx} < count_q);
    assign rd_data  = rd_valid ? mem_q[rd_ptr] : '0;
    assign count    = count_q;

endmodule

// File: rtl/riscv_run_monitor.sv
// rtl/riscv_run_monitor.sv - core reset sequencer, halt detector and write-back tracer
module riscv_run_monitor
    import riscv_sim_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH        = 8,
    parameter int unsigned     CNT_W        = 32,
    parameter int unsigned     RESET_CYCLES = 2,
    parameter int unsigned     HALT_RD      = 7,
    parameter logic [XLEN-1:0] HALT_PC      = '0,
    parameter int unsigned     HALT_PC_EN   = 0,
    parameter int unsigned     MAX_CYCLES   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          pc,
    input  logic [4:0]               rdId,
    input  logic                     regWrite,
    input  logic [XLEN-1:0]          wdata,
    output logic                     core_reset,
    output logic                     running,
    output logic                     done,
    output logic [1:0]               halt_cause,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         wb_count,
    input  logic [$clog2(DEPTH)-1:0] trace_idx,
    output logic                     trace_valid,
    output logic [XLEN-1:0]          trace_pc,
    output logic [4:0]               trace_rd,
    output logic [XLEN-1:0]          trace_data,
    output logic [$clog2(DEPTH):0]   trace_count
);
    localparam int unsigned HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned ENTRY_W = 2 * XLEN + 5;

    state_e             state_q, state_d;
    cause_e             cause_q, cause_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d, wb_q, wb_d;
    logic               in_run, wb_fire, hit_rd, hit_pc, hit_to, halt;
    logic [ENTRY_W-1:0] rd_entry;

    assign in_run  = (state_q == RUN);
    assign wb_fire = in_run && regWrite && (rdId != 5'd0);
    assign hit_rd  = wb_fire && (HALT_RD != 0) && (rdId == 5'(HALT_RD));
    assign hit_pc  = in_run && (HALT_PC_EN != 0) && (pc == HALT_PC);
    assign hit_to  = in_run && (MAX_CYCLES != 0) && (cyc_q == CNT_W'(MAX_CYCLES - 1));
    assign halt    = hit_rd || hit_pc || hit_to;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (hold_q == HOLD_W'(RESET_CYCLES)) state_d = RUN;
            RUN:     if (halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = HOLD;
        endcase
    end

    always_comb begin
        core_reset = (state_q == HOLD);
        running    = (state_q == RUN);
        done       = (state_q == HALTED);
    end

    // The halting cycle still counts and traces; HALTED freezes everything.
    always_comb begin
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        wb_d    = wb_q;
        cause_d = cause_q;
        if (state_q == HOLD && hold_q != HOLD_W'(RESET_CYCLES)) begin
            hold_d = hold_q + 1'b1;
        end
        if (in_run) begin
            cyc_d = cyc_q + 1'b1;
            if (wb_fire) wb_d = wb_q + 1'b1;
            if (hit_rd)      cause_d = RD;
            else if (hit_pc) cause_d = PC;
            else if (hit_to) cause_d = TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            cyc_q   <= '0;
            wb_q    <= '0;
            cause_q <= NONE;
        end else begin
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
            wb_q    <= wb_d;
            cause_q <= cause_d;
        end
    end

    assign halt_cause  = cause_q;
    assign cycle_count = cyc_q;
    assign wb_count    = wb_q;

    trace_ring #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_trace_ring (
        .clk       (clk),
        .reset     (reset),
        .push      (wb_fire),
        .push_data ({pc, rdId, wdata}),
        .rd_idx    (trace_idx),
        .rd_valid  (trace_valid),
        .rd_data   (rd_entry),
        .count     (trace_count)
    );

    assign trace_pc   = rd_entry[ENTRY_W-1 -: XLEN];
    assign trace_rd   = rd_entry[XLEN +: 5];
    assign trace_data = rd_entry[XLEN-1:0];

endmodule
